// File: rtl/add32_seq_pkg.sv
// Shared widths and FSM encoding for the two-pass 32-bit add/sub block.
package add32_seq_pkg;

  localparam int HALF_W = 16;
  localparam int FULL_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/add32_seq_rca.sv
// 16-bit ripple-carry adder built from explicit full-adder cells.
module add32_seq_rca
  import add32_seq_pkg::*;
(
  input  logic [HALF_W-1:0] a_i,
  input  logic [HALF_W-1:0] b_i,
  input  logic              ci_i,
  output logic [HALF_W-1:0] s_o,
  output logic              co_o
);

  logic [HALF_W:0] c_s;

  // Carry ripples LSB to MSB through one full-adder cell per bit.
  always_comb begin
    c_s    = '0;
    s_o    = '0;
    c_s[0] = ci_i;
    for (int i = 0; i < HALF_W; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c_s[i];
      c_s[i+1] = (a_i[i] & b_i[i]) | (c_s[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign co_o = c_s[HALF_W];

endmodule

// File: rtl/add32_seq.sv
// 32-bit add/sub computed in two passes (low half, then high half) through one
// shared 16-bit ripple-carry adder, with a valid/ready handshake on each side.
module add32_seq
  import add32_seq_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FULL_W-1:0] op_a,
  input  logic [FULL_W-1:0] op_b,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FULL_W-1:0] result,
  output logic              cout,
  output logic              ovf,
  output logic              busy
);

  state_e              state_q, state_d;
  logic [FULL_W-1:0]   a_q, b_q, result_q;
  logic                cin_q, c16_q, cout_q, ovf_q;
  logic                in_ready_q, out_valid_q, busy_q;
  logic [HALF_W-1:0]   add_a_s, add_b_s, add_sum_s;
  logic                add_ci_s, add_co_s;

  // Next-state logic; requests are only taken in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) state_d = LOW;
        else          state_d = IDLE;
      end
      LOW:  state_d = HIGH;
      HIGH: state_d = DONE;
      DONE: begin
        if (out_ready) state_d = IDLE;
        else           state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Adder operand mux: low half in LOW, high half with the stored carry otherwise.
  always_comb begin
    if (state_q == LOW) begin
      add_a_s  = a_q[HALF_W-1:0];
      add_b_s  = b_q[HALF_W-1:0];
      add_ci_s = cin_q;
    end else begin
      add_a_s  = a_q[FULL_W-1:HALF_W];
      add_b_s  = b_q[FULL_W-1:HALF_W];
      add_ci_s = c16_q;
    end
  end

  add32_seq_rca u_rca (
    .a_i  (add_a_s),
    .b_i  (add_b_s),
    .ci_i (add_ci_s),
    .s_o  (add_sum_s),
    .co_o (add_co_s)
  );

  // State, operand capture, per-pass result writes and registered status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      c16_q       <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= op_a;
            b_q   <= sub ? ~op_b : op_b;
            cin_q <= sub;
          end
        end
        LOW: begin
          result_q[HALF_W-1:0] <= add_sum_s;
          c16_q                <= add_co_s;
        end
        HIGH: begin
          result_q[FULL_W-1:HALF_W] <= add_sum_s;
          cout_q                    <= add_co_s;
          // Same-sign operands producing an opposite-sign result.
          ovf_q <= (a_q[FULL_W-1] == b_q[FULL_W-1]) &
                   (add_sum_s[HALF_W-1] != a_q[FULL_W-1]);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_add32_seq.sv
// Randomized self-checking bench for add32_seq against a plain-arithmetic model.
module tb_add32_seq;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        cout;
  logic        ovf;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  add32_seq dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, result} from integer arithmetic on the operands.
  function automatic logic [33:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint      sa, sb, sr;
    logic [32:0] u;
    logic        c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sr = s ? (sa - sb) : (sa + sb);
    v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    u  = s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    c  = s ? (a >= b) : u[32];
    return {v, c, u[31:0]};
  endfunction

  // Present a request at a negedge in IDLE; returns at the negedge after the accept edge.
  task automatic accept_req(input logic [31:0] a, input logic [31:0] b, input logic s);
    op_a     = a;
    op_b     = b;
    sub      = s;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    check_val("busy_after_accept", {63'd0, busy}, 64'd1);
    check_val("in_ready_after_accept", {63'd0, in_ready}, 64'd0);
  endtask

  task automatic wait_done(input string tag);
    int lat;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (out_valid !== 1'b1 && lat < 10);
    check_val(tag, 64'(lat), 64'd2);
  endtask

  task automatic check_res(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [33:0] e;
    e = ref_op(a, b, s);
    check_val("result", {32'd0, result}, {32'd0, e[31:0]});
    check_val("cout", {63'd0, cout}, {63'd0, e[32]});
    check_val("ovf", {63'd0, ovf}, {63'd0, e[33]});
  endtask

  // Full transaction with `hold` cycles of backpressure and ignored requests in DONE.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold);
    logic [33:0] e;
    e = ref_op(a, b, s);
    accept_req(a, b, s);
    wait_done("latency");
    check_res(a, b, s);
    for (int k = 0; k < hold; k++) begin
      op_a      = $urandom;
      op_b      = $urandom;
      sub       = 1'($urandom_range(0, 1));
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(negedge clock);
      check_val("hold_result", {32'd0, result}, {32'd0, e[31:0]});
      check_val("hold_in_ready", {63'd0, in_ready}, 64'd0);
      check_val("hold_out_valid", {63'd0, out_valid}, 64'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check_val("release_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("release_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  logic [31:0] va [6] = '{32'h0000FFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000005, 32'h80000000, 32'h00000000};
  logic [31:0] vb [6] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000007, 32'h00000001, 32'h00000000};
  logic        vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    logic [31:0] a, b, c, d;
    logic [33:0] e;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    sub       = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_result", {32'd0, result}, 64'd0);
    check_val("rst_cout", {63'd0, cout}, 64'd0);
    check_val("rst_ovf", {63'd0, ovf}, 64'd0);

    for (int i = 0; i < 6; i++) run_op(va[i], vb[i], vs[i], i % 3);

    // Backpressure with a waiting request that must be taken only after IDLE.
    a = 32'h12345678; b = 32'h0F0F0F0F; c = 32'hDEADBEEF; d = 32'h21524111;
    e = ref_op(a, b, 1'b0);
    accept_req(a, b, 1'b0);
    wait_done("bp_latency");
    for (int k = 0; k < 4; k++) begin
      op_a = c; op_b = d; sub = 1'b1; in_valid = 1'b1;
      @(negedge clock);
      check_val("bp_result", {32'd0, result}, {32'd0, e[31:0]});
      check_val("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check_val("bp_idle_in_ready", {63'd0, in_ready}, 64'd1);
    check_val("bp_idle_busy", {63'd0, busy}, 64'd0);
    @(negedge clock);
    in_valid = 1'b0;
    check_val("bp_next_accept", {63'd0, busy}, 64'd1);
    wait_done("bp2_latency");
    check_res(c, d, 1'b1);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;

    // Reset while the high pass is in progress.
    accept_req(32'hAAAA5555, 32'h5555AAAA, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_val("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("mid_rst_busy", {63'd0, busy}, 64'd0);
    check_val("mid_rst_result", {32'd0, result}, 64'd0);
    check_val("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check_val("mid_rst_no_stale", {63'd0, out_valid}, 64'd0);
    end

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 8 == 0) b = a;
      run_op(a, b, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
